// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors, default
// frame width and the 2-of-3 vote used by the receive sampler.
package uart_rx_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: line/config inputs and decoded outputs.
interface uart_rx_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  Par_err;
    logic                  Stp_err;
    logic                  Busy;

    // Driver side (line source and configuration owner)
    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, Data_valid, Par_err, Stp_err, Busy
    );

    // Receiver side
    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, Data_valid, Par_err, Stp_err, Busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three mid-bit samples and a majority vote.
// The vote is valid from edge Prescale/2+2 until the next bit's samples.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_en,
    input  logic [5:0] i_prescale,
    input  logic       i_rx,
    output logic       o_sampled_bit,
    output logic       o_sample_done,
    output logic       o_bit_end
);
    logic [5:0] r_edge_cnt;
    logic [5:0] w_half;
    logic [5:0] w_last;
    logic [2:0] w_samples;

    assign w_half    = {1'b0, i_prescale[5:1]};
    // Wraps to 63 for Prescale=0, so an illegal setting still ends each bit.
    assign w_last    = i_prescale - 6'd1;
    assign o_bit_end = i_en && (r_edge_cnt == w_last);

    // Edge counter: runs 0..Prescale-1 while enabled, held at 0 otherwise
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= 6'd0;
        end else if (!i_en || o_bit_end) begin
            r_edge_cnt <= 6'd0;
        end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sample
            logic [5:0] w_point;
            logic       r_sample;

            assign w_point = w_half + 6'(gi) - 6'd1;

            // Capture the line at Prescale/2-1, Prescale/2, Prescale/2+1
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    r_sample <= 1'b0;
                end else if (i_en && (r_edge_cnt == w_point)) begin
                    r_sample <= i_rx;
                end
            end

            assign w_samples[gi] = r_sample;
        end
    endgenerate

    assign o_sampled_bit = majority3(w_samples[0], w_samples[1], w_samples[2]);
    assign o_sample_done = i_en && (r_edge_cnt == (w_half + 6'd2));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: line synchronizer, frame FSM, LSB-first deserializer,
// parity and stop checks, single-cycle registered result strobes.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave rx_if
);
    localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic                  r_rx_meta;
    logic                  r_rx_s;
    uart_state_t           r_state,      w_state_next;
    logic [CNT_W-1:0]      r_bit_cnt,    w_bit_cnt_next;
    logic [DATA_WIDTH-1:0] r_shift,      w_shift_next;
    logic [DATA_WIDTH-1:0] r_pdata,      w_pdata_next;
    logic                  r_par_bad,    w_par_bad_next;
    logic [5:0]            r_prescale,   w_prescale_next;
    logic                  r_par_en,     w_par_en_next;
    logic                  r_par_typ,    w_par_typ_next;
    logic                  r_data_valid, w_data_valid_next;
    logic                  r_par_err,    w_par_err_next;
    logic                  r_stp_err,    w_stp_err_next;

    logic       w_cnt_en;
    logic [5:0] w_prescale_eff;
    logic       w_sampled_bit;
    logic       w_sample_done;
    logic       w_bit_end;
    logic       w_par_exp;

    // Two-flop synchronizer, idles high so reset never looks like a start bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_if.RX_IN;
            r_rx_s    <= r_rx_meta;
        end
    end

    // The falling-edge cycle in IDLE counts as edge 0 of the start bit, and
    // it must use the live Prescale because the latched copy is not yet loaded.
    assign w_cnt_en       = (r_state != IDLE) || !r_rx_s;
    assign w_prescale_eff = (r_state == IDLE) ? rx_if.Prescale : r_prescale;

    uart_rx_sampler u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .i_en          (w_cnt_en),
        .i_prescale    (w_prescale_eff),
        .i_rx          (r_rx_s),
        .o_sampled_bit (w_sampled_bit),
        .o_sample_done (w_sample_done),
        .o_bit_end     (w_bit_end)
    );

    assign w_par_exp = (r_par_typ == PAR_ODD) ? ~^r_shift : ^r_shift;

    // Next-state, datapath and strobe decode
    always_comb begin
        w_state_next      = r_state;
        w_bit_cnt_next    = r_bit_cnt;
        w_shift_next      = r_shift;
        w_pdata_next      = r_pdata;
        w_par_bad_next    = r_par_bad;
        w_prescale_next   = r_prescale;
        w_par_en_next     = r_par_en;
        w_par_typ_next    = r_par_typ;
        w_data_valid_next = 1'b0;
        w_par_err_next    = 1'b0;
        w_stp_err_next    = 1'b0;

        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_next    = START;
                    w_prescale_next = rx_if.Prescale;
                    w_par_en_next   = rx_if.PAR_EN;
                    w_par_typ_next  = rx_if.PAR_TYP;
                    w_par_bad_next  = 1'b0;
                    w_bit_cnt_next  = '0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    if (w_sampled_bit) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next   = DATA;
                        w_bit_cnt_next = '0;
                    end
                end
            end
            DATA: begin
                if (w_sample_done) begin
                    w_shift_next = {w_sampled_bit, r_shift[DATA_WIDTH-1:1]};
                end
                if (w_bit_end) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next   = r_par_en ? PARITY : STOP;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (w_sample_done) begin
                    w_par_bad_next = (w_sampled_bit != w_par_exp);
                end
                if (w_bit_end) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_next = IDLE;
                    if (r_par_bad) begin
                        w_par_err_next = 1'b1;
                    end else if (!w_sampled_bit) begin
                        w_stp_err_next = 1'b1;
                    end else begin
                        w_data_valid_next = 1'b1;
                        w_pdata_next      = r_shift;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath, latched frame configuration and result strobes
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_pdata      <= '0;
            r_par_bad    <= 1'b0;
            r_prescale   <= 6'd0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_bit_cnt    <= w_bit_cnt_next;
            r_shift      <= w_shift_next;
            r_pdata      <= w_pdata_next;
            r_par_bad    <= w_par_bad_next;
            r_prescale   <= w_prescale_next;
            r_par_en     <= w_par_en_next;
            r_par_typ    <= w_par_typ_next;
            r_data_valid <= w_data_valid_next;
            r_par_err    <= w_par_err_next;
            r_stp_err    <= w_stp_err_next;
        end
    end

    assign rx_if.P_DATA     = r_pdata;
    assign rx_if.Data_valid = r_data_valid;
    assign rx_if.Par_err    = r_par_err;
    assign rx_if.Stp_err    = r_stp_err;
    assign rx_if.Busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected outcomes are queued as frames are
// driven; a monitor queues observed strobes; each test pops and compares.
module tb_uart_rx;
    import uart_rx_pkg::*;

    typedef enum int {EV_VALID = 0, EV_PAR = 1, EV_STP = 2} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_if u_if ();

    uart_rx u_dut (
        .CLK   (clk),
        .RST   (rst_n),
        .rx_if (u_if)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    logic prev_strobe = 1'b0;

    // Monitor: record each strobe and check it is one-hot and single-cycle
    always @(negedge clk) begin
        logic [2:0] s;
        ev_t        o;
        s = {u_if.Data_valid, u_if.Par_err, u_if.Stp_err};
        if (!rst_n) begin
            prev_strobe = 1'b0;
        end else begin
            if (s != 3'b000) begin
                n_checks++;
                if ($countones(s) != 1 || prev_strobe)
                    $display("FAIL strobe_shape: dv/pe/se=%b prev=%b, required one-hot single-cycle", s, prev_strobe);
                else
                    n_pass++;
                o.kind = u_if.Data_valid ? EV_VALID : (u_if.Par_err ? EV_PAR : EV_STP);
                o.data = u_if.P_DATA;
                obs_q.push_back(o);
                $display("[%0t] strobe kind=%0d P_DATA=%02h", $time, o.kind, o.data);
            end
            prev_strobe = |s;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame at the current Prescale; flip_idx flips the centre
    // sample of that frame bit; abort_cyc stops early and idles the line.
    task automatic send_frame(input logic [7:0] data, input bit par_en, input bit par_bit,
                              input bit stop_bit, input int flip_idx, input int abort_cyc);
        bit   bits[$];
        int   p;
        int   cyc;
        logic v;
        p   = int'(u_if.Prescale);
        cyc = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (par_en) bits.push_back(par_bit);
        bits.push_back(stop_bit);
        $display("[%0t] send %02h P=%0d par_en=%0b par=%0b stop=%0b", $time, data, p, par_en, par_bit, stop_bit);
        for (int i = 0; i < bits.size(); i++) begin
            for (int c = 0; c < p; c++) begin
                if (cyc == abort_cyc) begin
                    u_if.RX_IN = 1'b1;
                    return;
                end
                v = bits[i];
                if (i == flip_idx && c == p / 2) v = ~v;
                u_if.RX_IN = v;
                tick(1);
                cyc++;
            end
        end
        u_if.RX_IN = 1'b1;
    endtask

    task automatic wait_outcome(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (obs_q.size() > 0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        u_if.RX_IN    = 1'b1;
        u_if.PAR_EN   = 1'b0;
        u_if.PAR_TYP  = 1'b0;
        u_if.Prescale = 6'd8;
        tick(3);
        n_checks++;
        if (u_if.P_DATA !== 8'h00) $display("FAIL reset_pdata: got %02h expected 00", u_if.P_DATA);
        else n_pass++;
        n_checks++;
        if ({u_if.Data_valid, u_if.Par_err, u_if.Stp_err} !== 3'b000)
            $display("FAIL reset_strobes: got %b expected 000", {u_if.Data_valid, u_if.Par_err, u_if.Stp_err});
        else n_pass++;
        n_checks++;
        if (u_if.Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", u_if.Busy);
        else n_pass++;
        rst_n = 1'b1;
        tick(3);
        n_checks++;
        if (u_if.Busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", u_if.Busy);
        else n_pass++;
    endtask

    task automatic test_basic;
        bit  got;
        ev_t e, o;
        u_if.Prescale = 6'd8;
        u_if.PAR_EN   = 1'b0;
        exp_q.push_back('{EV_VALID, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, -1);
        n_checks++;
        if (u_if.Busy !== 1'b1) $display("FAIL basic_busy_in_frame: got %b expected 1", u_if.Busy);
        else n_pass++;
        wait_outcome(got);
        n_checks++;
        if (!got) $display("FAIL basic_timeout: got no strobe expected Data_valid");
        else n_pass++;
        if (got) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.kind !== e.kind || o.data !== e.data)
                $display("FAIL basic_frame: got kind=%0d data=%02h expected kind=%0d data=%02h", o.kind, o.data, e.kind, e.data);
            else n_pass++;
        end
        tick(2);
        n_checks++;
        if (u_if.Busy !== 1'b0) $display("FAIL basic_busy_after: got %b expected 0", u_if.Busy);
        else n_pass++;
    endtask

    task automatic test_parity;
        bit  got;
        ev_t e, o;
        u_if.Prescale = 6'd16;
        u_if.PAR_EN   = 1'b1;
        u_if.PAR_TYP  = PAR_EVEN;
        // 0x3C has four ones: even parity bit is 0; sending 1 is a mismatch
        exp_q.push_back('{EV_VALID, 8'h3C});
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, -1);
        exp_q.push_back('{EV_PAR, 8'h3C});
        wait_outcome(got);
        n_checks++;
        if (!got) $display("FAIL parity_good_timeout: got no strobe expected Data_valid");
        else n_pass++;
        if (got) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.kind !== e.kind || o.data !== e.data)
                $display("FAIL parity_good: got kind=%0d data=%02h expected kind=%0d data=%02h", o.kind, o.data, e.kind, e.data);
            else n_pass++;
        end
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, -1);
        wait_outcome(got);
        n_checks++;
        if (!got) $display("FAIL parity_bad_timeout: got no strobe expected Par_err");
        else n_pass++;
        if (got) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.kind !== e.kind || o.data !== e.data)
                $display("FAIL parity_bad: got kind=%0d data=%02h expected kind=%0d data=%02h", o.kind, o.data, e.kind, e.data);
            else n_pass++;
        end
        tick(3);
        n_checks++;
        if (u_if.P_DATA !== 8'h3C) $display("FAIL parity_pdata_hold: got %02h expected 3C", u_if.P_DATA);
        else n_pass++;
    endtask

    task automatic test_stop_err;
        bit  got;
        ev_t e, o;
        u_if.Prescale = 6'd16;
        u_if.PAR_EN   = 1'b0;
        exp_q.push_back('{EV_STP, 8'h3C});
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1, -1);
        wait_outcome(got);
        n_checks++;
        if (!got) $display("FAIL stop_timeout: got no strobe expected Stp_err");
        else n_pass++;
        if (got) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.kind !== e.kind || o.data !== e.data)
                $display("FAIL stop_err: got kind=%0d data=%02h expected kind=%0d data=%02h", o.kind, o.data, e.kind, e.data);
            else n_pass++;
        end
        tick(3);
        n_checks++;
        if (u_if.P_DATA !== 8'h3C) $display("FAIL stop_pdata_hold: got %02h expected 3C", u_if.P_DATA);
        else n_pass++;
    endtask

    task automatic test_glitch;
        u_if.Prescale = 6'd16;
        u_if.PAR_EN   = 1'b0;
        u_if.RX_IN    = 1'b0;
        tick(3);
        u_if.RX_IN    = 1'b1;
        tick(2);
        n_checks++;
        if (u_if.Busy !== 1'b1) $display("FAIL glitch_busy_pulse: got %b expected 1", u_if.Busy);
        else n_pass++;
        tick(25);
        n_checks++;
        if (u_if.Busy !== 1'b0) $display("FAIL glitch_busy_after: got %b expected 0", u_if.Busy);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 0) $display("FAIL glitch_no_strobe: got %0d strobes expected 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit  got;
        ev_t e, o;
        u_if.Prescale = 6'd32;
        u_if.PAR_EN   = 1'b1;
        u_if.PAR_TYP  = PAR_ODD;
        // 0x55 and 0xAA each have four ones: odd parity bit is 1
        exp_q.push_back('{EV_VALID, 8'h55});
        exp_q.push_back('{EV_VALID, 8'hAA});
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, 4, -1);
        send_frame(8'hAA, 1'b1, 1'b1, 1'b1, -1, -1);
        for (int k = 0; k < 2; k++) begin
            wait_outcome(got);
            n_checks++;
            if (!got) $display("FAIL b2b_timeout_%0d: got no strobe expected Data_valid", k);
            else n_pass++;
            if (got) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_checks++;
                if (o.kind !== e.kind || o.data !== e.data)
                    $display("FAIL b2b_frame_%0d: got kind=%0d data=%02h expected kind=%0d data=%02h", k, o.kind, o.data, e.kind, e.data);
                else n_pass++;
            end
        end
        tick(3);
        n_checks++;
        if (obs_q.size() !== 0) $display("FAIL b2b_extra_strobes: got %0d expected 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midframe;
        bit  got;
        ev_t e, o;
        u_if.Prescale = 6'd8;
        u_if.PAR_EN   = 1'b0;
        // Abort inside data bit 4 (frame bit 5 spans cycles 40..47)
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, -1, 46);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({u_if.P_DATA, u_if.Data_valid, u_if.Par_err, u_if.Stp_err, u_if.Busy} !== 12'h000)
            $display("FAIL midreset_outputs: got pdata=%02h dv=%b pe=%b se=%b busy=%b expected all 0",
                     u_if.P_DATA, u_if.Data_valid, u_if.Par_err, u_if.Stp_err, u_if.Busy);
        else n_pass++;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        n_checks++;
        if (obs_q.size() !== 0 || u_if.Busy !== 1'b0)
            $display("FAIL midreset_aborted: got %0d strobes busy=%b expected 0 strobes busy=0", obs_q.size(), u_if.Busy);
        else n_pass++;
        exp_q.push_back('{EV_VALID, 8'h0F});
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, -1, -1);
        wait_outcome(got);
        n_checks++;
        if (!got) $display("FAIL midreset_timeout: got no strobe expected Data_valid");
        else n_pass++;
        if (got) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.kind !== e.kind || o.data !== e.data)
                $display("FAIL midreset_frame: got kind=%0d data=%02h expected kind=%0d data=%02h", o.kind, o.data, e.kind, e.data);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive-side frame decoder, the receive counterpart of the transmit path's start/data/parity/stop serializer.
- Synchronizes the asynchronous serial line and detects the start bit.
- Oversamples each bit by a runtime prescale factor and majority-votes three mid-bit samples.
- Deserializes data LSB first, checks optional parity and the stop bit.
- Presents the byte with a one-cycle valid strobe.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
CLK  input  1  oversampling clock (Prescale × baud rate).
RST  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, idle high, asynchronous to CLK.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Prescale  input  6  oversampling ratio; legal values are 8, 16 and 32.
P_DATA  output  DATA_WIDTH  last correctly received byte.
Data_valid  output  1  one-cycle strobe; P_DATA is new.
Par_err  output  1  one-cycle strobe; parity mismatch, frame dropped.
Stp_err  output  1  one-cycle strobe; stop bit sampled 0, frame dropped.
Busy  output  1  high while a frame is being received (state ≠ IDLE).

Behaviour:
- Reset (RST=0, async): state=IDLE; P_DATA=0, Data_valid=0, Par_err=0, Stp_err=0, Busy=0; synchronizer flops=1; all counters=0.
- Synchronizer: 2-flop synchronizer on RX_IN; all logic uses the synchronized value rx_s, giving 2 cycles of latency.
- Frame latching:
  - Prescale, PAR_EN and PAR_TYP are latched on the IDLE→START transition.
  - Changes mid-frame have no effect.
  - Illegal Prescale values give undefined reception but must never hang the FSM.
- Edge counter:
  - edge_cnt counts 0..Prescale-1 within each bit, then wraps to 0 and advances the bit.
  - Samples are taken at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - The bit value is the majority of the three samples, valid from edge_cnt = Prescale/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s==0 → START, with edge_cnt=0 in that same cycle.
  - START: at bit end (edge_cnt==Prescale-1), a voted start bit of 1 is a glitch → IDLE with no strobes; otherwise → DATA, bit_cnt=0.
  - DATA: shift the voted bit into the shift register LSB first. At the end of bit DATA_WIDTH-1, go to PARITY if PAR_EN, else STOP.
  - PARITY: the expected bit is ^data for even parity and ~^data for odd parity. Record a mismatch flag. At bit end → STOP.
  - STOP: on the cycle edge_cnt==Prescale-1 → IDLE, and exactly one outcome is pulsed for 1 cycle in the next cycle (registered):
    - parity mismatch → Par_err=1 (takes priority over a bad stop bit; Stp_err stays 0);
    - else stop bit voted 0 → Stp_err=1;
    - else Data_valid=1 and P_DATA = received byte.
- P_DATA changes only together with Data_valid and holds its value otherwise, including across erroneous frames.
- Back-to-back frames: a start bit immediately following the stop bit is detected from IDLE with no lost cycles beyond the 1-cycle STOP→IDLE transition.
- A line held low permanently: each frame reports Stp_err, then a new start is detected. There is no lockup.
- Reset mid-frame aborts immediately. No strobe is produced and the partial byte is discarded.
- Strobes are never asserted for more than 1 cycle and never simultaneously.

Decomposition:
- Shared uart package holds:
  - FSM state encoding (IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4);
  - parity type constants PAR_EVEN=1'b0, PAR_ODD=1'b1;
  - the default DATA_WIDTH.
- These constants are reused by the transmit-side FSM.
- One sub-module, uart_rx_sampler:
  - contents: edge counter, three-sample capture, majority vote;
  - outputs: sampled_bit, sample_done and bit_end.
- The FSM, deserializer, parity and stop checks live in uart_rx.

Test Plan:
1. Prescale=8, PAR_EN=0, send 0xA5 with stop=1 → one Data_valid pulse, P_DATA=0xA5, Par_err=Stp_err=0, Busy high for the frame then 0.
2. Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C:
   - parity bit 0 → Data_valid, P_DATA=0x3C;
   - repeat with parity bit 1 → Par_err pulse only, P_DATA stays 0x3C.
3. Prescale=16, PAR_EN=0, send 0x81 with stop bit 0 → Stp_err pulse, no Data_valid, P_DATA unchanged.
4. Prescale=16, drive RX_IN low for 3 cycles then high → FSM returns to IDLE after one bit time, no strobes, Busy pulses then 0.
5. Prescale=32, PAR_EN=1, PAR_TYP=1, send 0x55 then 0xAA back-to-back, with one of the three mid-bit samples flipped in bit 3 of 0x55 → two Data_valid pulses, P_DATA=0x55 then 0xAA, no errors.
6. Prescale=8, assert RST low during data bit 4 of 0xF0, release, then send 0x0F → all outputs 0 during reset, the aborted frame yields no strobe, then Data_valid with P_DATA=0x0F.
